// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute program-counter sequencer with halt/resume
// control and a saturating retired-instruction counter.
`default_nettype none

module pc_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int LAST_ADDR = 63,
  parameter int INSTR_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               exec_done,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               mem_req,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               halted,
  output logic [15:0]        retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(LAST_ADDR);
  // One bit wider so a LAST_ADDR at the top of the address space never
  // makes the range test trivially true or false through truncation.
  localparam logic [ADDR_W:0]   LAST_WIDE = (ADDR_W+1)'(LAST_ADDR);

  state_t              state;
  state_t              state_nxt;
  logic                halt_pend;
  logic                retire;
  logic                jump_oob;
  logic [ADDR_W-1:0]   pc_nxt;

  assign retire   = (state == EXEC) && exec_done;
  assign jump_oob = ({1'b0, jump_addr} > LAST_WIDE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (halt_pend) state_nxt = HALT;
               else if (start) state_nxt = FETCH;
      FETCH:   if (mem_ack) state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = (halt_pend || halt_req) ? HALT : FETCH;
      HALT:    if (start) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (retire) begin
      if (jump)               pc_nxt = jump_oob ? '0 : jump_addr;
      else if (pc == LAST_PC) pc_nxt = '0;
      else                    pc_nxt = pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Sticky until HALT is entered; requests seen while halted are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_pend <= 1'b0;
    end else if (state_nxt == HALT) begin
      halt_pend <= 1'b0;
    end else if (state != HALT && halt_req) begin
      halt_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
    end else if (state == FETCH && mem_ack) begin
      instr <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (retire && retired != 16'hFFFF) begin
      retired <= retired + 16'd1;
    end
  end

  assign mem_req     = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);

endmodule

`default_nettype wire
